// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART driver, the frame FIFO and the benches.
//   - DEFAULT_NUM_DATA_BITS : default data word width
//   - SYS_CLK / BAUD_RATE   : clocking assumptions used to derive bit timing
//   - BIT_DURATION          : sys_clk cycles per UART bit
//   - FRAME_BITS            : start + 8 data + stop bits on the line
//   - tx_state_e            : TX handshake FSM states
package uart_pkg;

  localparam int DEFAULT_NUM_DATA_BITS = 8;
  localparam int SYS_CLK               = 12_000_000;
  localparam int BAUD_RATE             = 115_200;
  localparam int BIT_DURATION          = SYS_CLK / BAUD_RATE;
  localparam int FRAME_BITS            = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_ACK    = 2'd2,
    ST_BUSY   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_frame_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered flags.
//   i_clk       : clock, rising edge
//   i_srst      : synchronous active-high reset
//   i_push      : write request; accepted when not full, or when full with a pop
//   i_push_data : word to write
//   i_pop       : read request; ignored when empty
//   o_rd_data   : head word captured on each accepted pop (holds otherwise)
//   o_count     : occupancy, 0..DEPTH
//   o_empty     : o_count == 0
//   o_full      : o_count == DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_NUM_DATA_BITS,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_srst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_do_pop;
  logic             w_do_push;
  logic [CW-1:0]    w_count_next;

  assign w_do_pop  = i_pop && !r_empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Storage carries no reset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;
  assign o_empty   = r_empty;
  assign o_full    = r_full;

endmodule

// File: rtl/uart_frame_fifo.sv
// uart_frame_fifo: store-and-forward buffer between the UART driver RX and TX sides.
//   sys_clk        : clock, rising edge
//   rst            : synchronous active-high reset
//   rx_new_data    : one-cycle pulse, rx_data valid in the same cycle
//   rx_data        : received word
//   tx_ready       : driver TX idle
//   tx_start       : one-cycle transmit request (LAUNCH state only)
//   tx_data        : word to transmit, stable from tx_start until back in IDLE
//   fifo_count     : occupancy
//   fifo_empty     : fifo_count == 0
//   fifo_full      : fifo_count == DEPTH
//   overflow       : sticky, set when a received word was dropped
//   clear_overflow : clears overflow (a simultaneous drop wins)
module uart_frame_fifo
  import uart_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS,
  parameter int DEPTH         = 16,
  parameter int ACK_TIMEOUT   = 8
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       rx_new_data,
  input  logic [NUM_DATA_BITS-1:0]   rx_data,
  input  logic                       tx_ready,
  output logic                       tx_start,
  output logic [NUM_DATA_BITS-1:0]   tx_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  tx_state_e     r_state;
  tx_state_e     w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          r_overflow;

  logic          w_pop;
  logic          w_drop;

  assign w_pop  = (r_state == ST_IDLE) && !fifo_empty && tx_ready;
  assign w_drop = rx_new_data && fifo_full && !w_pop;

  sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (sys_clk),
    .i_srst      (rst),
    .i_push      (rx_new_data),
    .i_push_data (rx_data),
    .i_pop       (w_pop),
    .o_rd_data   (tx_data),
    .o_count     (fifo_count),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_state_next = ST_ACK;
        w_timer_next = '0;
      end
      ST_ACK: begin
        // A driver that never drops ready is treated as having taken the word.
        if (!tx_ready) begin
          w_state_next = ST_BUSY;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      ST_BUSY: begin
        if (tx_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign tx_start = (r_state == ST_LAUNCH);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_frame_fifo.sv
module tb_uart_frame_fifo;
  import uart_pkg::*;

  localparam int W           = 8;
  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 8;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int BUSY_CYC    = BIT_DURATION * FRAME_BITS;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_new_data = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          tx_ready;
  logic          tx_start;
  logic [W-1:0]  tx_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  uart_frame_fifo #(
    .NUM_DATA_BITS (W),
    .DEPTH         (DEPTH),
    .ACK_TIMEOUT   (ACK_TIMEOUT)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .rx_new_data    (rx_new_data),
    .rx_data        (rx_data),
    .tx_ready       (tx_ready),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           pulse_cyc[$];
  int           launch_cnt = 0;
  logic [W-1:0] last_word = '0;
  bit           have_last = 1'b0;

  // Driver model control: 0 = manual level, 1 = busy for one frame per word, 2 = always ready
  int drv_mode     = 0;
  bit ready_manual = 1'b0;
  int busy_cnt     = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver model, updated shortly after each rising edge.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      case (drv_mode)
        0: tx_ready = ready_manual;
        1: begin
          if (busy_cnt > 0) begin
            busy_cnt--;
            tx_ready = (busy_cnt == 0);
          end else if (tx_start) begin
            tx_ready = 1'b0;
            busy_cnt = BUSY_CYC;
          end else begin
            tx_ready = 1'b1;
          end
        end
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: every tx_start pops the scoreboard; tx_data must hold between launches.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge sys_clk);
      if (tx_start) begin
        launch_cnt++;
        pulse_cyc.push_back(cyc);
        $display("[TB] launch %0d tx_data=0x%0h cyc=%0d", launch_cnt, tx_data, cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_launch: got tx_data 0x%0h expected no launch", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("launch_data", int'(tx_data), int'(e));
        end
        last_word = tx_data;
        have_last = 1'b1;
      end else if (have_last && !rst) begin
        check("tx_data_hold", int'(tx_data), int'(last_word));
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input bit accepted);
    rx_data     = d;
    rx_new_data = 1'b1;
    if (accepted) exp_q.push_back(d);
    $display("[TB] rx push 0x%0h (expect %s)", d, accepted ? "queued" : "dropped");
    @(negedge sys_clk);
    rx_new_data = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (launch_cnt >= target) break;
      @(negedge sys_clk);
    end
    check("launch_count", launch_cnt, target);
  endtask

  int push_c;
  int base;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;

    // Single word, latency 2
    drv_mode = 1;
    repeat (3) @(negedge sys_clk);
    push_c = cyc;
    push(8'h4A, 1'b1);
    check("single_count1", int'(fifo_count), 1);
    @(negedge sys_clk);
    check("single_count0", int'(fifo_count), 0);
    wait_launches(1, 10);
    if (pulse_cyc.size() >= 1) check("single_latency", pulse_cyc[0] - push_c, 2);
    repeat (BUSY_CYC + 30) @(negedge sys_clk);
    check("single_empty", int'(fifo_empty), 1);

    // Burst with TX blocked, then a dropped 17th word
    drv_mode     = 0;
    ready_manual = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int i = 1; i <= DEPTH; i++) push(W'(i), 1'b1);
    check("burst_full", int'(fifo_full), 1);
    check("burst_count", int'(fifo_count), DEPTH);
    check("burst_no_ovf", int'(overflow), 0);
    push(8'hFF, 1'b0);
    check("drop_overflow", int'(overflow), 1);
    check("drop_count", int'(fifo_count), DEPTH);
    check("drop_full", int'(fifo_full), 1);
    clear_overflow = 1'b1;
    @(negedge sys_clk);
    clear_overflow = 1'b0;
    check("clear_overflow", int'(overflow), 0);

    // Push while full in the same cycle as the IDLE->LAUNCH pop
    ready_manual = 1'b1;
    @(negedge sys_clk);
    drv_mode = 1;
    push(8'h5A, 1'b1);
    check("simul_count", int'(fifo_count), DEPTH);
    check("simul_overflow", int'(overflow), 0);
    check("simul_full", int'(fifo_full), 1);

    // Drain: 0x01..0x10 then 0x5A, in order
    wait_launches(1 + DEPTH + 1, (DEPTH + 1) * (BUSY_CYC + 20));
    repeat (BUSY_CYC + 30) @(negedge sys_clk);
    check("drain_empty", int'(fifo_empty), 1);
    check("drain_scoreboard_left", exp_q.size(), 0);
    check("drain_overflow", int'(overflow), 0);

    // ACK timeout with ready held high
    drv_mode = 2;
    repeat (3) @(negedge sys_clk);
    base = launch_cnt;
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    wait_launches(base + 2, 60);
    if (pulse_cyc.size() >= base + 2)
      check("timeout_gap", pulse_cyc[base + 1] - pulse_cyc[base], ACK_TIMEOUT + 2);
    repeat (20) @(negedge sys_clk);

    // Reset while BUSY with 3 words queued
    drv_mode = 1;
    repeat (3) @(negedge sys_clk);
    base = launch_cnt;
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    push(8'hA3, 1'b1);
    push(8'hA4, 1'b1);
    repeat (8) @(negedge sys_clk);
    check("busy_launches", launch_cnt, base + 1);
    check("busy_count", int'(fifo_count), 3);
    rst = 1'b1;
    exp_q.delete();
    have_last = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mrst_count", int'(fifo_count), 0);
    check("mrst_empty", int'(fifo_empty), 1);
    check("mrst_tx_start", int'(tx_start), 0);
    check("mrst_tx_data", int'(tx_data), 0);
    check("mrst_overflow", int'(overflow), 0);
    drv_mode = 2;
    repeat (40) @(negedge sys_clk);
    check("mrst_no_launch", launch_cnt, base + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
